alu_mc: RTL and testbench

Parametrised multi-cycle ALU, the next-generation execution unit for the multi-cycle/pipelined CPU datapath. Covers all logic, shift, add/sub and compare ops in one registered cycle, plus iterative unsigned multiply and divide. A start/busy/done handshake lets the control FSM stall while long ops run.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_iter.sv | 75 +++++++
 rtl/alu_mc.sv | 170 +++++++++++++++++
 tb/tb_alu_mc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared op-code and FSM state definitions for the multi-cycle ALU and its control decoder.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_MULU = 4'b1011;
    localparam logic [3:0] ALU_DIVU = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Purpose: shared one-bit-per-cycle shift-add multiplier / restoring divider (only built with ALU_MULDIV_EN).
// Latency: operands load on start; done is high while lo/hi show the final (WIDTH-th) step, WIDTH-1 edges later.
// Backpressure: none; the owner must hold off start until done and capture lo/hi on the done cycle.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,      // 0: multiply, 1: divide
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic             run;
    logic             mode_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opd_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // lo/hi present the state after the next step so the owner can capture the final step without an extra cycle
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        // remainder stays below the divisor, so the top bit of the difference is exactly the borrow
        div_diff  = div_shift - {1'b0, opd_q};
        if (mode_q) begin
            hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            hi = mul_sum[WIDTH:1];
            lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        done = run && (cnt == SHW'(WIDTH - 1));
    end

    // operand load on start, then one iteration per cycle until the final step is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            mode_q <= 1'b0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
        end else if (start) begin
            run    <= 1'b1;
            mode_q <= mode;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= a;
            opd_q  <= b;
        end else if (run) begin
            hi_q <= hi;
            lo_q <= lo;
            cnt  <= cnt + SHW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_mc.sv
// Purpose: multi-cycle ALU; logic/shift/add/compare in one cycle, iterative MULU/DIVU when ALU_MULDIV_EN is defined.
// Latency: done 1 cycle after accepted start; MULU and non-zero-divisor DIVU take WIDTH+1 cycles.
// Backpressure: busy from acceptance through the done cycle; start is ignored unless idle, nothing is queued.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             div0
);

    localparam int MSB = WIDTH - 1;

    alu_state_t       state;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] hi_c;
    logic             ovf_c;
    logic             div0_c;

    // single-cycle datapath, evaluated on the live operands and captured at start acceptance
    always_comb begin
        sum    = a + b;
        diff   = a - b;
        shamt  = b[SHW-1:0];
        res_c  = '0;
        hi_c   = '0;
        ovf_c  = 1'b0;
        div0_c = 1'b0;
        case (op)
            ALU_AND:  res_c = a & b;
            ALU_OR:   res_c = a | b;
            ALU_ADD: begin
                res_c = sum;
                ovf_c = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_XOR:  res_c = a ^ b;
            ALU_NOR:  res_c = ~(a | b);
            ALU_SLL:  res_c = a << shamt;
            ALU_SUB: begin
                res_c = diff;
                ovf_c = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_SLT:  res_c = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: res_c = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SRL:  res_c = a >> shamt;
            ALU_SRA:  res_c = $unsigned($signed(a) >>> shamt);
`ifdef ALU_MULDIV_EN
            // a zero divisor short-circuits the iteration and finishes in one cycle
            ALU_DIVU: begin
                if (b == '0) begin
                    res_c  = '1;
                    hi_c   = a;
                    div0_c = 1'b1;
                end
            end
`endif
            default: res_c = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             go_mul;
    logic             go_div;
    logic             it_start;
    logic             it_done;
    logic [WIDTH-1:0] it_lo;
    logic [WIDTH-1:0] it_hi;

    // decide at acceptance whether the op needs the iterative unit
    always_comb begin
        go_mul   = (op == ALU_MULU);
        go_div   = (op == ALU_DIVU) && (b != '0);
        it_start = (state == ST_IDLE) && start && (go_mul || go_div);
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (it_start),
        .mode  (go_div),
        .a     (a),
        .b     (b),
        .done  (it_done),
        .lo    (it_lo),
        .hi    (it_hi)
    );
`endif

    // control FSM with all outputs registered; flags only change when an op completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            div0      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
`ifdef ALU_MULDIV_EN
                        if (go_mul) begin
                            state <= ST_MUL;
                        end else if (go_div) begin
                            state <= ST_DIV;
                        end else
`endif
                        begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            result    <= res_c;
                            result_hi <= hi_c;
                            zero      <= (res_c == '0);
                            ovf       <= ovf_c;
                            div0      <= div0_c;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    if (it_done) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        result    <= it_lo;
                        result_hi <= it_hi;
                        zero      <= (it_lo == '0);
                        ovf       <= 1'b0;
                        div0      <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Purpose: self-checking bench for alu_mc (32-bit and 16-bit instances), expectations follow ALU_MULDIV_EN.
// Latency: checks done latency per op, including the iterative WIDTH+1 cycle ops.
// Backpressure: checks busy hold, ignored start while busy and start coinciding with done.
module tb_alu_mc;
    import alu_pkg::*;

`ifdef ALU_MULDIV_EN
    localparam int LMD = 33;
`else
    localparam int LMD = 1;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        logic        d0;
        int          lat;
        logic        mid;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        ovf;
    logic        div0;

    logic        start16;
    logic [3:0]  op16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] result16;
    logic [15:0] result_hi16;
    logic        zero16;
    logic        ovf16;
    logic        div016;

    int errors = 0;
    int checks = 0;
    vec_t vt[20];

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .zero(zero), .ovf(ovf), .div0(div0)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .result_hi(result_hi16),
        .zero(zero16), .ovf(ovf16), .div0(div016)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // apply one vector to the 32-bit DUT and check latency, busy, outputs and the done one-shot
    task automatic run_vec(input vec_t v, input string nm);
        int   lat;
        logic busy_ok;
        logic got;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk);
        #1;
        start = 1'b0; op = ALU_AND; a = ~v.a; b = 32'h3;
        lat = 0; busy_ok = 1'b1; got = 1'b0;
        while (lat < 100 && !got) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                start = v.mid && (lat == 5);
                op = ALU_ADD;
            end
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, got, 1'b1);
        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_busy_held"}, {busy_ok, busy}, 2'b11);
        chk({nm, "_res"}, result, v.res);
        chk({nm, "_hi"}, result_hi, v.hi);
        chk({nm, "_flags"}, {zero, ovf, div0}, {v.z, v.ov, v.d0});
        @(negedge clk);
        chk({nm, "_after_done"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int   seen;
        vec_t vadd;

        vt[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vt[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vt[2]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[3]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vt[4]  = '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[5]  = '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[6]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[7]  = '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[8]  = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[9]  = '{ALU_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[10] = '{ALU_SLL,  32'h00000001, 32'h00000024, 32'h00000010, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[11] = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vt[12] = '{4'b1101,  32'h12345678, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vt[13] = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vt[14] = '{4'b1111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
`ifdef ALU_MULDIV_EN
        vt[15] = '{ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, LMD, 1'b1};
        vt[16] = '{ALU_DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, LMD, 1'b0};
        vt[17] = '{ALU_DIVU, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 1'b1, 1,   1'b0};
        vt[18] = '{ALU_MULU, 32'd3,        32'd4,        32'd12,       32'd0,        1'b0, 1'b0, 1'b0, LMD, 1'b0};
        vt[19] = '{ALU_DIVU, 32'd10,       32'd11,       32'd0,        32'd10,       1'b1, 1'b0, 1'b0, LMD, 1'b0};
`else
        vt[15] = '{ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, LMD, 1'b1};
        vt[16] = '{ALU_DIVU, 32'd100,      32'd7,        32'h0, 32'h0, 1'b1, 1'b0, 1'b0, LMD, 1'b0};
        vt[17] = '{ALU_DIVU, 32'd9,        32'd0,        32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1,   1'b0};
        vt[18] = '{ALU_MULU, 32'd3,        32'd4,        32'h0, 32'h0, 1'b1, 1'b0, 1'b0, LMD, 1'b0};
        vt[19] = '{ALU_DIVU, 32'd10,       32'd11,       32'h0, 32'h0, 1'b1, 1'b0, 1'b0, LMD, 1'b0};
`endif
        vadd = '{ALU_ADD, 32'h00000011, 32'h00000022, 32'h00000033, 32'h0, 1'b0, 1'b0, 1'b0, 1, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        #3;
        chk("reset_ctrl", {busy, done, zero, ovf, div0}, 5'b0);
        chk("reset_res", {result_hi, result}, 64'h0);
        chk("reset16", {busy16, done16, zero16, ovf16, div016, result16, result_hi16}, 37'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_vec(vt[i], $sformatf("v%0d", i));
        end

        // start asserted during the done cycle is ignored, then accepted once idle
        @(negedge clk);
        start = 1'b1; op = ALU_ADD; a = 32'd1; b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("cd_first_done", {done, result}, {1'b1, 32'd3});
        start = 1'b1; op = ALU_OR; a = 32'h0F; b = 32'hF0;
        @(negedge clk);
        chk("cd_ignored", {busy, done}, 2'b00);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("cd_second_done", {done, result}, {1'b1, 32'hFF});
        @(negedge clk);

        // asynchronous reset during an operation clears outputs and suppresses done
        @(negedge clk);
`ifdef ALU_MULDIV_EN
        start = 1'b1; op = ALU_MULU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_busy_before", {busy, done}, 2'b10);
`else
        start = 1'b1; op = ALU_ADD; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_before", {done, result}, {1'b1, 32'd5});
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy, done, zero, ovf, div0}, 5'b0);
        chk("rst_mid_res", {result_hi, result}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("rst_mid_no_done", seen, 0);
        run_vec(vadd, "post_rst_add");

        // 16-bit instance: signed overflow at the narrower width
        @(negedge clk);
        start16 = 1'b1; op16 = ALU_ADD; a16 = 16'h7FFF; b16 = 16'h0001;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(negedge clk);
        chk("w16_add_done", {done16, busy16}, 2'b11);
        chk("w16_add_res", {result_hi16, result16}, {16'h0, 16'h8000});
        chk("w16_add_flags", {zero16, ovf16, div016}, 3'b010);
        @(negedge clk);
        start16 = 1'b1; op16 = ALU_SUB; a16 = 16'h8000; b16 = 16'h0001;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        @(negedge clk);
        chk("w16_sub_res", {done16, result16, ovf16}, {1'b1, 16'h7FFF, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
